// File: rtl/sdram_port_arbiter_pkg.sv
// Shared request-interface defaults for the SDRAM port arbiter and its picker.
// Default widths match the SDRAM controller's fabric-side port.
package sdram_port_arbiter_pkg;

  localparam int SDRAM_NUM_PORTS  = 4;
  localparam int SDRAM_ADDR_WIDTH = 23;
  localparam int SDRAM_DATA_WIDTH = 32;
  localparam int SDRAM_RD_TIMEOUT = 64;

  // Next port index with wrap to zero at n.
  function automatic int wrap_inc(input int v, input int n);
    return ((v + 1) >= n) ? 0 : (v + 1);
  endfunction

endpackage

// File: rtl/sdram_rr_pick.sv
// Round-robin picker: rotates the request vector so the port after rr_ptr sits
// at bit 0, priority-encodes the lowest set bit, then un-rotates the index.
module sdram_rr_pick
  import sdram_port_arbiter_pkg::*;
#(
  parameter int NUM_PORTS = SDRAM_NUM_PORTS
) (
  input  logic [NUM_PORTS-1:0]         req,
  input  logic [$clog2(NUM_PORTS)-1:0] rr_ptr,
  output logic                         any,
  output logic [$clog2(NUM_PORTS)-1:0] idx
);

  localparam int IW = $clog2(NUM_PORTS);

  logic [2*NUM_PORTS-1:0] dbl_s;
  logic [NUM_PORTS-1:0]   rot_s;
  logic                   found_s;
  int                     start_s;
  int                     enc_s;
  int                     sum_s;

  // Rotate, priority-encode and un-rotate the request vector.
  always_comb begin
    start_s = wrap_inc(int'(rr_ptr), NUM_PORTS);
    dbl_s   = {req, req};
    rot_s   = NUM_PORTS'(dbl_s >> start_s);
    found_s = 1'b0;
    enc_s   = 0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (rot_s[i] && !found_s) begin
        found_s = 1'b1;
        enc_s   = i;
      end else begin
        enc_s   = enc_s;
      end
    end
    sum_s = enc_s + start_s;
    if (sum_s >= NUM_PORTS) begin
      sum_s = sum_s - NUM_PORTS;
    end else begin
      sum_s = sum_s;
    end
    any = |req;
    idx = IW'(sum_s);
  end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Shares the SDRAM controller's single request/ack port between NUM_PORTS
// requesters with round-robin arbitration and one transaction in flight.
module sdram_port_arbiter
  import sdram_port_arbiter_pkg::*;
#(
  parameter int NUM_PORTS  = SDRAM_NUM_PORTS,
  parameter int ADDR_WIDTH = SDRAM_ADDR_WIDTH,
  parameter int DATA_WIDTH = SDRAM_DATA_WIDTH,
  parameter int RD_TIMEOUT = SDRAM_RD_TIMEOUT
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic [NUM_PORTS-1:0]             p_req,
  input  logic [NUM_PORTS-1:0]             p_wr_en,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  p_addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  p_wr_data,
  output logic [NUM_PORTS-1:0]             p_ack,
  output logic [NUM_PORTS-1:0]             p_rd_valid,
  output logic [DATA_WIDTH-1:0]            p_rd_data,
  output logic                             ctrl_req,
  output logic                             ctrl_wr_en,
  output logic [ADDR_WIDTH-1:0]            ctrl_addr,
  output logic [DATA_WIDTH-1:0]            ctrl_wr_data,
  input  logic                             ctrl_ack,
  input  logic                             ctrl_rd_valid,
  input  logic [DATA_WIDTH-1:0]            ctrl_rd_data,
  output logic                             busy,
  output logic                             err_timeout
);

  localparam int IW = $clog2(NUM_PORTS);
  localparam int CW = $clog2(RD_TIMEOUT + 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_GRANT   = 2'd1;
  localparam logic [1:0] ST_RD_WAIT = 2'd2;

  localparam logic [CW-1:0] CNT_LAST = CW'(RD_TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(RD_TIMEOUT);

  logic [1:0]           state_r;
  logic [IW-1:0]        gnt_idx_r;
  logic [IW-1:0]        rr_ptr_r;
  logic [CW-1:0]        cnt_r;
  logic                 any_s;
  logic [IW-1:0]        idx_s;
  logic [NUM_PORTS-1:0] gnt_onehot_s;

  sdram_rr_pick #(.NUM_PORTS(NUM_PORTS)) u_pick (
    .req    (p_req),
    .rr_ptr (rr_ptr_r),
    .any    (any_s),
    .idx    (idx_s)
  );

  // Acknowledge the owning port in the very cycle the controller accepts.
  always_comb begin
    gnt_onehot_s            = {NUM_PORTS{1'b0}};
    gnt_onehot_s[gnt_idx_r] = 1'b1;
    if ((state_r == ST_GRANT) && ctrl_ack) begin
      p_ack = gnt_onehot_s;
    end else begin
      p_ack = {NUM_PORTS{1'b0}};
    end
  end

  assign busy = (state_r != ST_IDLE);

  // Arbitration FSM, latched command, read-data return and timeout tracking.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= ST_IDLE;
      gnt_idx_r    <= {IW{1'b0}};
      rr_ptr_r     <= IW'(NUM_PORTS - 1);
      cnt_r        <= {CW{1'b0}};
      ctrl_req     <= 1'b0;
      ctrl_wr_en   <= 1'b0;
      ctrl_addr    <= {ADDR_WIDTH{1'b0}};
      ctrl_wr_data <= {DATA_WIDTH{1'b0}};
      p_rd_valid   <= {NUM_PORTS{1'b0}};
      p_rd_data    <= {DATA_WIDTH{1'b0}};
      err_timeout  <= 1'b0;
    end else begin
      p_rd_valid <= {NUM_PORTS{1'b0}};
      case (state_r)
        ST_IDLE: begin
          if (any_s) begin
            gnt_idx_r    <= idx_s;
            rr_ptr_r     <= idx_s;
            ctrl_wr_en   <= p_wr_en[idx_s];
            ctrl_addr    <= p_addr[int'(idx_s)*ADDR_WIDTH +: ADDR_WIDTH];
            ctrl_wr_data <= p_wr_data[int'(idx_s)*DATA_WIDTH +: DATA_WIDTH];
            ctrl_req     <= 1'b1;
            state_r      <= ST_GRANT;
          end else begin
            state_r      <= ST_IDLE;
          end
        end
        ST_GRANT: begin
          if (ctrl_ack) begin
            ctrl_req <= 1'b0;
            cnt_r    <= {CW{1'b0}};
            state_r  <= ctrl_wr_en ? ST_IDLE : ST_RD_WAIT;
          end else begin
            state_r  <= ST_GRANT;
          end
        end
        ST_RD_WAIT: begin
          // Data arriving on the last allowed cycle still beats the timeout.
          if (ctrl_rd_valid) begin
            p_rd_data  <= ctrl_rd_data;
            p_rd_valid <= gnt_onehot_s;
            state_r    <= ST_IDLE;
          end else if (cnt_r == CNT_LAST) begin
            err_timeout <= 1'b1;
            state_r     <= ST_IDLE;
          end else if (cnt_r != CNT_MAX) begin
            cnt_r <= cnt_r + CW'(1);
          end else begin
            cnt_r <= cnt_r;
          end
        end
        default: begin
          ctrl_req <= 1'b0;
          state_r  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter: hand-written corner sequences plus a
// table of round-robin grant vectors with hand-computed winners.
module tb_sdram_port_arbiter;

  localparam int N  = 4;
  localparam int AW = 23;
  localparam int DW = 32;
  localparam int TO = 64;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [N-1:0]    p_req;
  logic [N-1:0]    p_wr_en;
  logic [N*AW-1:0] p_addr;
  logic [N*DW-1:0] p_wr_data;
  logic [N-1:0]    p_ack;
  logic [N-1:0]    p_rd_valid;
  logic [DW-1:0]   p_rd_data;
  logic            ctrl_req;
  logic            ctrl_wr_en;
  logic [AW-1:0]   ctrl_addr;
  logic [DW-1:0]   ctrl_wr_data;
  logic            ctrl_ack;
  logic            ctrl_rd_valid;
  logic [DW-1:0]   ctrl_rd_data;
  logic            busy;
  logic            err_timeout;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [N-1:0] req;
    int           exp_idx;
  } vec_t;
  vec_t vecs [10];

  sdram_port_arbiter #(.NUM_PORTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n), .p_req(p_req), .p_wr_en(p_wr_en), .p_addr(p_addr),
    .p_wr_data(p_wr_data), .p_ack(p_ack), .p_rd_valid(p_rd_valid), .p_rd_data(p_rd_data),
    .ctrl_req(ctrl_req), .ctrl_wr_en(ctrl_wr_en), .ctrl_addr(ctrl_addr),
    .ctrl_wr_data(ctrl_wr_data), .ctrl_ack(ctrl_ack), .ctrl_rd_valid(ctrl_rd_valid),
    .ctrl_rd_data(ctrl_rd_data), .busy(busy), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  function automatic logic [AW-1:0] port_addr(input int i);
    return 23'h10000 + AW'(i) * 23'h111;
  endfunction

  function automatic logic [DW-1:0] port_data(input int i);
    return 32'hA5A50000 + DW'(i);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic do_reset();
    reset_n       = 1'b0;
    p_req         = '0;
    p_wr_en       = '0;
    ctrl_ack      = 1'b0;
    ctrl_rd_valid = 1'b0;
    ctrl_rd_data  = '0;
    for (int i = 0; i < N; i++) begin
      p_addr[i*AW +: AW]    = port_addr(i);
      p_wr_data[i*DW +: DW] = port_data(i);
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    vecs[0] = '{4'b0001, 0};
    vecs[1] = '{4'b1111, 1};
    vecs[2] = '{4'b0001, 0};
    vecs[3] = '{4'b1001, 3};
    vecs[4] = '{4'b1001, 0};
    vecs[5] = '{4'b0100, 2};
    vecs[6] = '{4'b0101, 0};
    vecs[7] = '{4'b1100, 2};
    vecs[8] = '{4'b1110, 3};
    vecs[9] = '{4'b0110, 1};

    // Reset values
    do_reset();
    settle();
    chk("rst_ctrl_req", 64'(ctrl_req), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_err", 64'(err_timeout), 64'd0);
    chk("rst_p_ack", 64'(p_ack), 64'd0);
    chk("rst_rd_valid", 64'(p_rd_valid), 64'd0);
    chk("rst_rd_data", 64'(p_rd_data), 64'd0);
    chk("rst_ctrl_addr", 64'(ctrl_addr), 64'd0);

    // Test 1: port 0 write, ack on the third GRANT cycle
    p_addr[0 +: AW]    = 23'h12345;
    p_wr_data[0 +: DW] = 32'hDEADBEEF;
    p_wr_en = 4'b0001;
    p_req   = 4'b0001;
    settle();
    chk("t1_req_before", 64'(ctrl_req), 64'd0);
    next(); settle();
    chk("t1_ctrl_req", 64'(ctrl_req), 64'd1);
    chk("t1_addr", 64'(ctrl_addr), 64'h12345);
    chk("t1_wdata", 64'(ctrl_wr_data), 64'hDEADBEEF);
    chk("t1_wr_en", 64'(ctrl_wr_en), 64'd1);
    chk("t1_busy", 64'(busy), 64'd1);
    chk("t1_no_ack_c1", 64'(p_ack), 64'd0);
    next(); settle();
    chk("t1_no_ack_c2", 64'(p_ack), 64'd0);
    next();
    ctrl_ack = 1'b1;
    settle();
    chk("t1_p_ack", 64'(p_ack), 64'b0001);
    next();
    ctrl_ack = 1'b0;
    p_req    = '0;
    settle();
    chk("t1_req_drop", 64'(ctrl_req), 64'd0);
    chk("t1_idle", 64'(busy), 64'd0);

    // Test 2: all ports requesting continuously, ack after 2 cycles
    do_reset();
    p_req   = 4'b1111;
    p_wr_en = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      next(); settle();
      chk("t2_ctrl_req", 64'(ctrl_req), 64'd1);
      chk("t2_addr", 64'(ctrl_addr), 64'(port_addr(k % N)));
      next();
      ctrl_ack = 1'b1;
      settle();
      chk("t2_order", 64'(p_ack), 64'(4'b0001 << (k % N)));
      next();
      ctrl_ack = 1'b0;
    end
    p_req = '0;

    // Test 3: port 2 read, data 6 cycles after ack
    p_req   = 4'b0100;
    p_wr_en = 4'b0000;
    next();
    ctrl_ack = 1'b1;
    settle();
    chk("t3_p_ack", 64'(p_ack), 64'b0100);
    chk("t3_wr_en", 64'(ctrl_wr_en), 64'd0);
    next();
    ctrl_ack = 1'b0;
    p_req    = '0;
    repeat (5) next();
    ctrl_rd_valid = 1'b1;
    ctrl_rd_data  = 32'hCAFEF00D;
    settle();
    chk("t3_rv_early", 64'(p_rd_valid), 64'd0);
    next();
    ctrl_rd_valid = 1'b0;
    settle();
    chk("t3_rd_valid", 64'(p_rd_valid), 64'b0100);
    chk("t3_rd_data", 64'(p_rd_data), 64'hCAFEF00D);
    chk("t3_idle", 64'(busy), 64'd0);
    next(); settle();
    chk("t3_rv_pulse", 64'(p_rd_valid), 64'd0);

    // Test 4: read with no data returned -> timeout
    p_req = 4'b0010;
    next();
    ctrl_ack = 1'b1;
    settle();
    chk("t4_p_ack", 64'(p_ack), 64'b0010);
    next();
    ctrl_ack = 1'b0;
    p_req    = '0;
    repeat (TO - 1) next();
    settle();
    chk("t4_err_early", 64'(err_timeout), 64'd0);
    chk("t4_busy_wait", 64'(busy), 64'd1);
    next(); settle();
    chk("t4_err", 64'(err_timeout), 64'd1);
    chk("t4_idle", 64'(busy), 64'd0);
    ctrl_rd_valid = 1'b1;
    ctrl_rd_data  = 32'h11112222;
    next();
    ctrl_rd_valid = 1'b0;
    settle();
    chk("t4_late_rv", 64'(p_rd_valid), 64'd0);
    chk("t4_err_sticky", 64'(err_timeout), 64'd1);

    // Test 5: reset during GRANT, then during RD_WAIT
    p_req   = 4'b0100;
    p_wr_en = 4'b0100;
    next(); settle();
    chk("t5_grant", 64'(ctrl_req), 64'd1);
    reset_n  = 1'b0;
    p_req    = '0;
    ctrl_ack = 1'b1;
    settle();
    chk("t5_g_ctrl_req", 64'(ctrl_req), 64'd0);
    chk("t5_g_busy", 64'(busy), 64'd0);
    chk("t5_g_p_ack", 64'(p_ack), 64'd0);
    chk("t5_g_err", 64'(err_timeout), 64'd0);
    ctrl_ack = 1'b0;
    next();
    reset_n = 1'b1;
    p_req   = 4'b0100;
    p_wr_en = 4'b0000;
    next();
    ctrl_ack = 1'b1;
    settle();
    chk("t5_rd_ack", 64'(p_ack), 64'b0100);
    next();
    ctrl_ack = 1'b0;
    p_req    = '0;
    settle();
    chk("t5_rdwait", 64'(busy), 64'd1);
    reset_n = 1'b0;
    settle();
    chk("t5_r_busy", 64'(busy), 64'd0);
    chk("t5_r_ctrl_req", 64'(ctrl_req), 64'd0);
    ctrl_rd_valid = 1'b1;
    next();
    settle();
    chk("t5_r_rv", 64'(p_rd_valid), 64'd0);
    ctrl_rd_valid = 1'b0;
    reset_n = 1'b1;
    next();
    p_req   = 4'b0101;
    p_wr_en = 4'b0101;
    next(); settle();
    chk("t5_first_addr", 64'(ctrl_addr), 64'(port_addr(0)));
    ctrl_ack = 1'b1;
    settle();
    chk("t5_first_ack", 64'(p_ack), 64'b0001);
    next();
    ctrl_ack = 1'b0;
    p_req    = '0;

    // Test 6: spurious controller strobes while idle
    ctrl_ack      = 1'b1;
    ctrl_rd_valid = 1'b1;
    ctrl_rd_data  = 32'h55AA55AA;
    settle();
    chk("t6_p_ack", 64'(p_ack), 64'd0);
    next();
    ctrl_ack      = 1'b0;
    ctrl_rd_valid = 1'b0;
    settle();
    chk("t6_rv", 64'(p_rd_valid), 64'd0);
    chk("t6_busy", 64'(busy), 64'd0);
    chk("t6_ctrl_req", 64'(ctrl_req), 64'd0);
    p_req   = 4'b0010;
    p_wr_en = 4'b0010;
    next(); settle();
    chk("t6_after_req", 64'(ctrl_req), 64'd1);
    chk("t6_after_addr", 64'(ctrl_addr), 64'(port_addr(1)));
    ctrl_ack = 1'b1;
    settle();
    chk("t6_after_ack", 64'(p_ack), 64'b0010);
    next();
    ctrl_ack = 1'b0;
    p_req    = '0;

    // Round-robin vector table, starting from reset
    do_reset();
    p_wr_en = 4'b1111;
    for (int v = 0; v < 10; v++) begin
      p_req = vecs[v].req;
      next(); settle();
      chk("tbl_ctrl_req", 64'(ctrl_req), 64'd1);
      chk("tbl_addr", 64'(ctrl_addr), 64'(port_addr(vecs[v].exp_idx)));
      chk("tbl_wdata", 64'(ctrl_wr_data), 64'(port_data(vecs[v].exp_idx)));
      ctrl_ack = 1'b1;
      settle();
      chk("tbl_p_ack", 64'(p_ack), 64'(4'b0001 << vecs[v].exp_idx));
      next();
      ctrl_ack = 1'b0;
      p_req    = '0;
      settle();
      chk("tbl_idle", 64'(busy), 64'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
